// File: rtl/al_const_capture.sv
// Auto-load constant capture: buffers one flash parameter block, validates its checksum
// (and its header word when AL_CAP_MAGIC_CHECK_EN is defined), then commits the payload.
module al_const_capture #(
    parameter int NWORDS = 64
`ifdef AL_CAP_MAGIC_CHECK_EN
    ,
    parameter logic [15:0] MAGIC = 16'hDCFE
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        AL_ENA,
    input  logic        RBK_WE,
    input  logic [15:0] RBK_DATA,
    output logic        CONST_WE,
    output logic [5:0]  CONST_ADDR,
    output logic [15:0] CONST_DATA,
    output logic        CAP_DONE,
    output logic [3:0]  CAP_STATUS,
    output logic [6:0]  CAP_WCNT
);

    localparam logic [6:0] WCNT_FULL = 7'(NWORDS);
    localparam logic [5:0] NPAY      = 6'(NWORDS - 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_CHECK   = 3'd2,
        S_COMMIT  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state_r;
    logic        ena_d_r;
    logic [15:0] acc_r;
    logic [5:0]  k_r;
    logic [15:0] shadow_r [NWORDS];

    logic        al_rise_s;
    logic        cap_we_s;
    logic [6:0]  wcnt_nxt_s;
    logic [15:0] acc_nxt_s;
    logic        magic_err_s;
    logic        cksum_err_s;

    // Checksum is a plain 16-bit sum; the carry out is intentionally dropped.
    function automatic logic [15:0] cksum_add(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    // Capture qualification, next-count/accumulator values and block validation flags.
    always_comb begin
        al_rise_s   = AL_ENA & ~ena_d_r;
        cap_we_s    = (state_r == S_CAPTURE) && RBK_WE && (CAP_WCNT < WCNT_FULL);
        wcnt_nxt_s  = CAP_WCNT;
        acc_nxt_s   = acc_r;
        if (cap_we_s) begin
            wcnt_nxt_s = CAP_WCNT + 7'd1;
            acc_nxt_s  = cksum_add(acc_r, RBK_DATA);
        end else begin
            wcnt_nxt_s = CAP_WCNT;
            acc_nxt_s  = acc_r;
        end
        cksum_err_s = (acc_r != 16'h0000);
`ifdef AL_CAP_MAGIC_CHECK_EN
        magic_err_s = (shadow_r[0] != MAGIC);
`else
        magic_err_s = 1'b0;
`endif
    end

    // Shadow buffer holding the block until it has been validated.
    always_ff @(posedge CLK) begin
        if (cap_we_s) begin
            shadow_r[CAP_WCNT[5:0]] <= RBK_DATA;
        end
    end

    // Capture/check/commit sequencer with registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= S_IDLE;
            ena_d_r    <= 1'b0;
            acc_r      <= 16'h0000;
            k_r        <= 6'd0;
            CONST_WE   <= 1'b0;
            CONST_ADDR <= 6'd0;
            CONST_DATA <= 16'h0000;
            CAP_DONE   <= 1'b0;
            CAP_STATUS <= 4'b0000;
            CAP_WCNT   <= 7'd0;
        end else begin
            ena_d_r  <= AL_ENA;
            CAP_DONE <= 1'b0;
            CONST_WE <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (al_rise_s) begin
                        state_r    <= S_CAPTURE;
                        CAP_STATUS <= 4'b0000;
                        CAP_WCNT   <= 7'd0;
                        acc_r      <= 16'h0000;
                    end
                end
                S_CAPTURE: begin
                    CAP_WCNT <= wcnt_nxt_s;
                    acc_r    <= acc_nxt_s;
                    // A strobe that completes the block wins over a simultaneous window drop.
                    if (CAP_WCNT == WCNT_FULL) begin
                        state_r <= S_CHECK;
                    end else if (!AL_ENA && (wcnt_nxt_s != WCNT_FULL)) begin
                        CAP_STATUS[1] <= 1'b1;
                        CAP_DONE      <= 1'b1;
                        state_r       <= S_DONE;
                    end
                end
                S_CHECK: begin
                    k_r <= 6'd0;
                    if (magic_err_s || cksum_err_s) begin
                        CAP_STATUS[3] <= magic_err_s;
                        CAP_STATUS[2] <= cksum_err_s;
                        CAP_DONE      <= 1'b1;
                        state_r       <= S_DONE;
                    end else begin
                        state_r <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (k_r == NPAY) begin
                        CAP_STATUS[0] <= 1'b1;
                        CAP_DONE      <= 1'b1;
                        state_r       <= S_DONE;
                    end else begin
                        CONST_WE   <= 1'b1;
                        CONST_ADDR <= k_r;
                        CONST_DATA <= shadow_r[k_r + 6'd1];
                        k_r        <= k_r + 6'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_al_const_capture.sv
// Bench for al_const_capture: directed and randomized blocks checked against a
// block-level model of which words must reach the constants file.
module tb_al_const_capture;

    localparam int NW = 64;

    logic        CLK = 1'b0;
    logic        RST;
    logic        AL_ENA;
    logic        RBK_WE;
    logic [15:0] RBK_DATA;
    logic        CONST_WE;
    logic [5:0]  CONST_ADDR;
    logic [15:0] CONST_DATA;
    logic        CAP_DONE;
    logic [3:0]  CAP_STATUS;
    logic [6:0]  CAP_WCNT;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int last_cyc;
    logic [21:0] wr_q [$];
    int          wr_cyc_q [$];
    logic [15:0] blk [NW];

    al_const_capture dut (
        .CLK(CLK), .RST(RST), .AL_ENA(AL_ENA), .RBK_WE(RBK_WE), .RBK_DATA(RBK_DATA),
        .CONST_WE(CONST_WE), .CONST_ADDR(CONST_ADDR), .CONST_DATA(CONST_DATA),
        .CAP_DONE(CAP_DONE), .CAP_STATUS(CAP_STATUS), .CAP_WCNT(CAP_WCNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Log every constants-file write and every done pulse, away from the active edge.
    always @(negedge CLK) begin
        if (CONST_WE === 1'b1) begin
            wr_q.push_back({CONST_ADDR, CONST_DATA});
            wr_cyc_q.push_back(cyc);
        end
        if (CAP_DONE === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Block with the right header, given payload, and a closing two's-complement checksum.
    task automatic build_block(input bit directed, input logic [15:0] hdr);
        logic [15:0] s;
        blk[0] = hdr;
        for (int i = 1; i < NW - 1; i++) blk[i] = directed ? 16'(i) : 16'($urandom);
        s = 16'h0000;
        for (int i = 0; i < NW - 1; i++) s = s + blk[i];
        blk[NW-1] = 16'h0000 - s;
    endtask

    function automatic logic [3:0] exp_status(input int n);
        logic [15:0] s;
        logic mb, cb;
        s = 16'h0000;
        for (int i = 0; i < NW; i++) s = s + blk[i];
        mb = 1'b0;
`ifdef AL_CAP_MAGIC_CHECK_EN
        mb = (blk[0] != 16'hDCFE);
`endif
        cb = (s != 16'h0000);
        if (n < NW) return 4'b0010;
        if (mb || cb) return {mb, cb, 2'b00};
        return 4'b0001;
    endfunction

    task automatic drive_block(input int n, input bit drop);
        AL_ENA = 1'b0;
        @(posedge CLK); #1;
        AL_ENA = 1'b1;
        @(posedge CLK); #1;
        last_cyc = -1;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
            RBK_WE   = 1'b1;
            RBK_DATA = (i < NW) ? blk[i] : 16'($urandom);
            @(posedge CLK); #1;
            RBK_WE = 1'b0;
            if (i == NW - 1) last_cyc = cyc;
        end
        if (drop) AL_ENA = 1'b0;
    endtask

    task automatic run_case(input string tag, input int n, input bit drop);
        int bw, bd, nexp, errs;
        logic [3:0] es;
        bw = wr_q.size();
        bd = done_cnt;
        es = exp_status(n);
        drive_block(n, drop);
        for (int t = 0; t < 300 && done_cnt == bd; t++) begin @(posedge CLK); #1; end
        repeat (2) @(posedge CLK);
        #1;
        check({tag, ".done"}, 32'(done_cnt - bd), 32'd1);
        check({tag, ".status"}, 32'(CAP_STATUS), 32'(es));
        check({tag, ".wcnt"}, 32'(CAP_WCNT), 32'((n < NW) ? n : NW));
        nexp = es[0] ? NW - 2 : 0;
        check({tag, ".nwr"}, 32'(wr_q.size() - bw), 32'(nexp));
        if (nexp > 0) begin
            errs = 0;
            for (int k = 0; k < nexp; k++)
                if (bw + k >= wr_q.size() || wr_q[bw+k] !== {6'(k), blk[k+1]}) errs++;
            check({tag, ".wdata"}, 32'(errs), 32'd0);
            if (wr_cyc_q.size() >= bw + nexp) begin
                check({tag, ".lat"}, 32'(wr_cyc_q[bw] - last_cyc), 32'd3);
                check({tag, ".gapless"}, 32'(wr_cyc_q[bw+nexp-1] - wr_cyc_q[bw]), 32'(nexp - 1));
            end
        end
        // No restart while the window level is simply held.
        bd = done_cnt;
        repeat (4) @(posedge CLK);
        #1;
        check({tag, ".norestart"}, 32'(done_cnt - bd), 32'd0);
        check({tag, ".hold"}, 32'(CAP_STATUS), 32'(es));
        AL_ENA = 1'b0;
    endtask

    initial begin
        int bw, bd, nwe, mode;
        RST = 1'b1; AL_ENA = 1'b0; RBK_WE = 1'b0; RBK_DATA = 16'h0000;
        repeat (3) @(posedge CLK);
        #1;
        check("rst.we",     32'(CONST_WE),   32'd0);
        check("rst.addr",   32'(CONST_ADDR), 32'd0);
        check("rst.data",   32'(CONST_DATA), 32'd0);
        check("rst.done",   32'(CAP_DONE),   32'd0);
        check("rst.status", 32'(CAP_STATUS), 32'd0);
        check("rst.wcnt",   32'(CAP_WCNT),   32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        build_block(1'b1, 16'hDCFE);
        run_case("good", NW, 1'b0);

        blk[NW-1] = blk[NW-1] ^ 16'h0001;
        run_case("badck", NW, 1'b0);

        build_block(1'b1, 16'hDCFE);
        run_case("short", 40, 1'b1);

        run_case("overrun", 70, 1'b0);

        // Reset while the commit is in flight.
        build_block(1'b0, 16'hDCFE);
        bw = wr_q.size();
        bd = done_cnt;
        drive_block(NW, 1'b0);
        nwe = 0;
        for (int t = 0; t < 200 && nwe < 10; t++) begin
            @(posedge CLK); #1;
            if (CONST_WE === 1'b1) nwe++;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rstc.we",     32'(CONST_WE),   32'd0);
        check("rstc.status", 32'(CAP_STATUS), 32'd0);
        check("rstc.wcnt",   32'(CAP_WCNT),   32'd0);
        RST = 1'b0;
        check("rstc.nwr",  32'(wr_q.size() - bw), 32'd10);
        check("rstc.done", 32'(done_cnt - bd),    32'd0);
        build_block(1'b1, 16'hDCFE);
        run_case("afterrst", NW, 1'b0);

        build_block(1'b0, 16'h1234);
        run_case("magic", NW, 1'b0);

        for (int r = 0; r < 4; r++) begin
            build_block(1'b0, 16'hDCFE);
            mode = int'($urandom_range(0, 2));
            if (mode == 1) begin
                int p;
                p = int'($urandom_range(1, NW - 2));
                blk[p] = blk[p] ^ 16'(32'd1 << $urandom_range(0, 15));
            end
            if (mode == 2) run_case($sformatf("rnd%0d", r), int'($urandom_range(1, NW - 1)), 1'b1);
            else run_case($sformatf("rnd%0d", r), NW + int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
